// File: rtl/port_pkg.sv
// Shared types and helpers for the switch port transmit block.
package port_pkg;

    typedef enum logic [1:0] {
        SINGLE    = 2'd0,
        MULTICAST = 2'd1,
        BROADCAST = 2'd2
    } ptype_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        GAP  = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SRC  = 2'd1;
    localparam logic [1:0] ERR_TGT  = 2'd2;
    localparam logic [1:0] ERR_LEN  = 2'd3;

    function automatic logic [2:0] countones(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/port_hdr_check.sv
// Combinational header validation and packet-type classification.
module port_hdr_check
    import port_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int MAX_LEN = 16
) (
    input  logic [3:0] source,
    input  logic [3:0] target,
    input  logic [7:0] len,
    output logic       ok,
    output logic [1:0] err_code,
    output ptype_e     ptype
);

    localparam logic [3:0] SRC_EXP   = 4'(1 << PORT_ID);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic src_ok;
    logic tgt_bcast;
    logic tgt_ok;
    logic len_ok;

    // Matching the single legal mask also guarantees the source is one-hot.
    assign src_ok    = (source == SRC_EXP);
    assign tgt_bcast = (target == 4'hF);
    assign tgt_ok    = tgt_bcast || ((target != 4'h0) && ((target & source) == 4'h0));
    assign len_ok    = (len != 8'd0) && (len <= MAX_LEN_B);
    assign ok        = src_ok && tgt_ok && len_ok;

    always_comb begin
        if (!src_ok)      err_code = ERR_SRC;
        else if (!tgt_ok) err_code = ERR_TGT;
        else if (!len_ok) err_code = ERR_LEN;
        else              err_code = ERR_NONE;
    end

    always_comb begin
        if (tgt_bcast)                   ptype = BROADCAST;
        else if (countones(target) == 1) ptype = SINGLE;
        else                             ptype = MULTICAST;
    end

endmodule

// File: rtl/port_if.sv
// Transmit-side link: validates a packet header and serialises header, length
// and payload bytes onto the switch input port under suspend back-pressure.
module port_if
    import port_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [3:0]  pkt_source,
    input  logic [3:0]  pkt_target,
    input  logic [7:0]  pkt_len,
    input  logic        pl_valid,
    input  logic [7:0]  pl_data,
    output logic        pl_ready,
    input  logic        suspend_ip,
    output logic        valid_ip,
    output logic [7:0]  data_ip,
    output logic [1:0]  ptype,
    output logic        busy,
    output logic        hdr_err,
    output logic [1:0]  err_code,
    output logic [15:0] pkt_count
);

    state_e      state_q, state_d;
    logic [3:0]  src_q, src_d;
    logic [3:0]  tgt_q, tgt_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    ptype_e      ptype_q, ptype_d;
    logic        hdr_err_q, hdr_err_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] count_q, count_d;

    logic        chk_ok;
    logic [1:0]  chk_err;
    ptype_e      chk_ptype;
    logic        load_en;
    logic        pl_ready_c;

    port_hdr_check #(
        .PORT_ID (PORT_ID),
        .MAX_LEN (MAX_LEN)
    ) u_hdr_check (
        .source   (pkt_source),
        .target   (pkt_target),
        .len      (pkt_len),
        .ok       (chk_ok),
        .err_code (chk_err),
        .ptype    (chk_ptype)
    );

    assign load_en = !valid_q || !suspend_ip;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        tgt_d      = tgt_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ptype_d    = ptype_q;
        hdr_err_d  = 1'b0;
        err_d      = err_q;
        count_d    = count_q;
        pl_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    if (chk_ok) begin
                        src_d   = pkt_source;
                        tgt_d   = pkt_target;
                        len_d   = pkt_len;
                        cnt_d   = 8'd0;
                        ptype_d = chk_ptype;
                        state_d = HDR;
                    end else begin
                        hdr_err_d = 1'b1;
                        err_d     = chk_err;
                    end
                end
            end
            HDR: begin
                if (load_en) begin
                    data_d  = {tgt_q, src_q};
                    valid_d = 1'b1;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (load_en) begin
                    data_d  = len_q;
                    valid_d = 1'b1;
                    state_d = PAY;
                end
            end
            PAY: begin
                // Once every payload byte is loaded, wait for the last one to leave.
                if (cnt_q != len_q) begin
                    pl_ready_c = load_en;
                    if (load_en) begin
                        valid_d = pl_valid;
                        if (pl_valid) begin
                            data_d = pl_data;
                            cnt_d  = cnt_q + 8'd1;
                        end
                    end
                end else if (load_en) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                count_d = count_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            tgt_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ptype_q   <= SINGLE;
            hdr_err_q <= 1'b0;
            err_q     <= ERR_NONE;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            tgt_q     <= tgt_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ptype_q   <= ptype_d;
            hdr_err_q <= hdr_err_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    // Ready is gated by reset so that every output reads 0 while reset is held.
    assign pkt_ready = (state_q == IDLE) && !reset;
    assign pl_ready  = pl_ready_c;
    assign valid_ip  = valid_q;
    assign data_ip   = data_q;
    assign ptype     = ptype_q;
    assign busy      = (state_q != IDLE);
    assign hdr_err   = hdr_err_q;
    assign err_code  = err_q;
    assign pkt_count = count_q;

endmodule

// File: tb/tb_port_if.sv
// Directed bench for port_if (PORT_ID=0, MAX_LEN=16).
module tb_port_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [3:0]  pkt_source = 4'h0;
    logic [3:0]  pkt_target = 4'h0;
    logic [7:0]  pkt_len = 8'h0;
    logic        pl_valid = 1'b0;
    logic [7:0]  pl_data = 8'h0;
    logic        pl_ready;
    logic        suspend_ip = 1'b0;
    logic        valid_ip;
    logic [7:0]  data_ip;
    logic [1:0]  ptype;
    logic        busy;
    logic        hdr_err;
    logic [1:0]  err_code;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] pay [0:15];
    logic [7:0] got [$];

    always #5 clk = ~clk;

    port_if #(
        .PORT_ID (0),
        .MAX_LEN (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_source (pkt_source),
        .pkt_target (pkt_target),
        .pkt_len    (pkt_len),
        .pl_valid   (pl_valid),
        .pl_data    (pl_data),
        .pl_ready   (pl_ready),
        .suspend_ip (suspend_ip),
        .valid_ip   (valid_ip),
        .data_ip    (data_ip),
        .ptype      (ptype),
        .busy       (busy),
        .hdr_err    (hdr_err),
        .err_code   (err_code),
        .pkt_count  (pkt_count)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one header, feeds the payload from pay[], optionally suspends on a
    // given payload byte and/or drops pl_valid at a given payload index.
    task automatic run_frame(input string tag, input logic [3:0] src, input logic [3:0] tgt,
                             input logic [7:0] len, input logic [7:0] hdr_exp,
                             input int sus_at, input int sus_n, input int bub_at, input int bub_n);
        int idx = 0;
        int sus_left = sus_n;
        int bub_left = bub_n;
        int first = -1;
        int last = -1;
        int holes = 0;
        bit took;
        bit prev_sus = 1'b0;
        logic [7:0] held = 8'h0;
        logic [7:0] exp_b;
        got.delete();
        check({tag, " pkt_ready"}, 16'(pkt_ready), 16'd1);
        pkt_valid = 1'b1; pkt_source = src; pkt_target = tgt; pkt_len = len;
        tick();
        pkt_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (got.size() >= int'(len) + 2) break;
            if (prev_sus) begin
                check({tag, " hold data"}, 16'(data_ip), 16'(held));
                check({tag, " hold valid"}, 16'(valid_ip), 16'd1);
            end
            suspend_ip = valid_ip && (got.size() == sus_at + 2) && (sus_left > 0);
            prev_sus = suspend_ip;
            if (suspend_ip) begin
                sus_left--;
                held = data_ip;
            end
            #1;
            if (suspend_ip) check({tag, " pl_ready in hold"}, 16'(pl_ready), 16'd0);
            pl_valid = (idx < int'(len));
            if (pl_valid && pl_ready && idx == bub_at && bub_left > 0) begin
                pl_valid = 1'b0;
                bub_left--;
            end
            pl_data = pay[idx[3:0]];
            #1;
            took = pl_valid && pl_ready;
            if (valid_ip && !suspend_ip) begin
                got.push_back(data_ip);
                if (first < 0) first = t;
                last = t;
            end else if (!valid_ip && first >= 0) begin
                holes++;
            end
            tick();
            if (took) idx++;
        end
        suspend_ip = 1'b0;
        pl_valid = 1'b0;
        check({tag, " byte count"}, 16'(got.size()), 16'(len) + 16'd2);
        for (int i = 0; i < int'(len) + 2; i++) begin
            exp_b = (i == 0) ? hdr_exp : (i == 1) ? len : pay[i - 2];
            check($sformatf("%s byte%0d", tag, i), 16'((i < got.size()) ? got[i] : 8'hxx), 16'(exp_b));
        end
        check({tag, " latency"}, 16'(first), 16'd1);
        check({tag, " frame cycles"}, 16'(last - first + 1), 16'(int'(len) + 2 + sus_n + bub_n));
        check({tag, " bubbles"}, 16'(holes), 16'(bub_n));
        check({tag, " gap valid"}, 16'(valid_ip), 16'd0);
        check({tag, " gap busy"}, 16'(busy), 16'd1);
        tick();
        check({tag, " idle busy"}, 16'(busy), 16'd0);
        check({tag, " idle valid"}, 16'(valid_ip), 16'd0);
        $display("frame %s: %0d bytes over %0d cycles", tag, got.size(), last - first + 1);
    endtask

    task automatic reject(input string tag, input logic [3:0] src, input logic [3:0] tgt,
                          input logic [7:0] len, input logic [1:0] code, input logic [15:0] cnt_exp);
        pkt_valid = 1'b1; pkt_source = src; pkt_target = tgt; pkt_len = len;
        tick();
        pkt_valid = 1'b0;
        check({tag, " hdr_err"}, 16'(hdr_err), 16'd1);
        check({tag, " err_code"}, 16'(err_code), 16'(code));
        check({tag, " busy"}, 16'(busy), 16'd0);
        check({tag, " valid_ip"}, 16'(valid_ip), 16'd0);
        tick();
        check({tag, " hdr_err pulse"}, 16'(hdr_err), 16'd0);
        check({tag, " valid_ip after"}, 16'(valid_ip), 16'd0);
        check({tag, " pkt_count"}, pkt_count, cnt_exp);
        $display("reject %s: err_code=%0d", tag, err_code);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_ip", 16'(valid_ip), 16'd0);
        check("reset busy", 16'(busy), 16'd0);
        check("reset pkt_ready", 16'(pkt_ready), 16'd0);
        check("reset pkt_count", pkt_count, 16'd0);
        check("reset err_code", 16'(err_code), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        run_frame("single", 4'h1, 4'h2, 8'd3, 8'h21, -1, 0, -1, 0);
        check("single ptype", 16'(ptype), 16'd0);
        check("single count", pkt_count, 16'd1);

        pay[0] = 8'h5C;
        run_frame("bcast", 4'h1, 4'hF, 8'd1, 8'hF1, -1, 0, -1, 0);
        check("bcast ptype", 16'(ptype), 16'd2);
        check("bcast count", pkt_count, 16'd2);

        pay[0] = 8'h11; pay[1] = 8'h22;
        run_frame("mcast", 4'h1, 4'h6, 8'd2, 8'h61, -1, 0, -1, 0);
        check("mcast ptype", 16'(ptype), 16'd1);
        check("mcast count", pkt_count, 16'd3);

        reject("bad src", 4'h2, 4'h1, 8'd3, 2'd1, 16'd3);
        reject("tgt has src", 4'h1, 4'h3, 8'd3, 2'd2, 16'd3);
        reject("tgt zero", 4'h1, 4'h0, 8'd3, 2'd2, 16'd3);
        reject("len 0", 4'h1, 4'h2, 8'd0, 2'd3, 16'd3);
        reject("len 17", 4'h1, 4'h2, 8'd17, 2'd3, 16'd3);
        check("ptype kept after rejects", 16'(ptype), 16'd1);

        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        run_frame("suspend", 4'h1, 4'h2, 8'd3, 8'h21, 1, 3, -1, 0);
        check("suspend count", pkt_count, 16'd4);

        pay[0] = 8'hB1; pay[1] = 8'hB2; pay[2] = 8'hB3; pay[3] = 8'hB4;
        run_frame("bubble", 4'h1, 4'h4, 8'd4, 8'h41, -1, 0, 2, 2);
        check("bubble count", pkt_count, 16'd5);

        // Abandon a packet mid-payload with an asynchronous reset.
        pkt_valid = 1'b1; pkt_source = 4'h1; pkt_target = 4'h2; pkt_len = 8'd3;
        pl_valid = 1'b1; pl_data = 8'hA1;
        tick();
        pkt_valid = 1'b0;
        repeat (3) tick();
        check("pre-reset busy", 16'(busy), 16'd1);
        check("pre-reset data", 16'(data_ip), 16'h00A1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset valid_ip", 16'(valid_ip), 16'd0);
        check("async reset busy", 16'(busy), 16'd0);
        check("async reset pkt_count", pkt_count, 16'd0);
        $display("reset mid-payload: valid_ip=%0d busy=%0d pkt_count=%0d", valid_ip, busy, pkt_count);
        @(negedge clk);
        reset = 1'b0;
        pl_valid = 1'b0;
        tick();

        pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3;
        run_frame("after reset", 4'h1, 4'h8, 8'd3, 8'h81, -1, 0, -1, 0);
        check("after reset count", pkt_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
